// File: rtl/timing_test_host_if.sv
// Handshake and result bus between the SoC-side controller and timing_test_host.
// The master drives requests and the test-block result; the slave is the host itself.
interface timing_test_host_if;
  logic        start_i;
  logic [7:0]  runs_i;
  logic [31:0] tt_data_i;
  logic        we_o;
  logic        busy_o;
  logic        done_o;
  logic [9:0]  err_last_o;
  logic [9:0]  err_min_o;
  logic [9:0]  err_max_o;
  logic [17:0] err_sum_o;
  logic [7:0]  fail_runs_o;
  logic [7:0]  run_cnt_o;

  modport master (
    output start_i,
    output runs_i,
    output tt_data_i,
    input  we_o,
    input  busy_o,
    input  done_o,
    input  err_last_o,
    input  err_min_o,
    input  err_max_o,
    input  err_sum_o,
    input  fail_runs_o,
    input  run_cnt_o
  );

  modport slave (
    input  start_i,
    input  runs_i,
    input  tt_data_i,
    output we_o,
    output busy_o,
    output done_o,
    output err_last_o,
    output err_min_o,
    output err_max_o,
    output err_sum_o,
    output fail_runs_o,
    output run_cnt_o
  );
endinterface

// File: rtl/timing_test_host.sv
// Initiator for the inverter-chain timing test: launches runs via we_o, waits a settle
// window, samples the 10-bit error count and accumulates min/max/sum/fail statistics.
module timing_test_host #(
  parameter int unsigned WE_HOLD  = 3,
  parameter int unsigned RUN_WAIT = 600,
  parameter int unsigned GAP      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  timing_test_host_if.slave    bus
);

  localparam int unsigned CntMax0 = (WE_HOLD > GAP) ? WE_HOLD : GAP;
  localparam int unsigned CntMax  = (RUN_WAIT > CntMax0) ? RUN_WAIT : CntMax0;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWait,
    StSample,
    StGap,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      runs_q, runs_d;
  logic [9:0]      err_last_q, err_last_d;
  logic [9:0]      err_min_q, err_min_d;
  logic [9:0]      err_max_q, err_max_d;
  logic [17:0]     err_sum_q, err_sum_d;
  logic [7:0]      fail_runs_q, fail_runs_d;
  logic [7:0]      run_cnt_q, run_cnt_d;

  logic [9:0]      sample;
  logic            unused_tt_data;

  assign sample         = bus.tt_data_i[9:0];
  assign unused_tt_data = ^bus.tt_data_i[31:10];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    runs_d      = runs_q;
    err_last_d  = err_last_q;
    err_min_d   = err_min_q;
    err_max_d   = err_max_q;
    err_sum_d   = err_sum_q;
    fail_runs_d = fail_runs_q;
    run_cnt_d   = run_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          // A request for zero runs still performs one characterisation run.
          runs_d      = (bus.runs_i == 8'd0) ? 8'd1 : bus.runs_i;
          err_min_d   = 10'h3FF;
          err_max_d   = 10'd0;
          err_sum_d   = 18'd0;
          fail_runs_d = 8'd0;
          run_cnt_d   = 8'd0;
          cnt_d       = '0;
          state_d     = StArm;
        end
      end

      StArm: begin
        if (cnt_q == CntW'(WE_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StWait: begin
        if (cnt_q == CntW'(RUN_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StSample: begin
        err_last_d = sample;
        err_min_d  = (sample < err_min_q) ? sample : err_min_q;
        err_max_d  = (sample > err_max_q) ? sample : err_max_q;
        err_sum_d  = err_sum_q + {8'd0, sample};
        if (sample != 10'd0) begin
          fail_runs_d = fail_runs_q + 8'd1;
        end
        run_cnt_d = run_cnt_q + 8'd1;
        cnt_d     = '0;
        state_d   = ((run_cnt_q + 8'd1) == runs_q) ? StDone : StGap;
      end

      StGap: begin
        if (cnt_q == CntW'(GAP - 1)) begin
          cnt_d   = '0;
          state_d = StArm;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      runs_q      <= 8'd0;
      err_last_q  <= 10'd0;
      err_min_q   <= 10'h3FF;
      err_max_q   <= 10'd0;
      err_sum_q   <= 18'd0;
      fail_runs_q <= 8'd0;
      run_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      runs_q      <= runs_d;
      err_last_q  <= err_last_d;
      err_min_q   <= err_min_d;
      err_max_q   <= err_max_d;
      err_sum_q   <= err_sum_d;
      fail_runs_q <= fail_runs_d;
      run_cnt_q   <= run_cnt_d;
    end
  end

  // we_o decodes straight from the state register so it cannot glitch.
  assign bus.we_o        = (state_q == StArm);
  assign bus.busy_o      = (state_q != StIdle);
  assign bus.done_o      = (state_q == StDone);
  assign bus.err_last_o  = err_last_q;
  assign bus.err_min_o   = err_min_q;
  assign bus.err_max_o   = err_max_q;
  assign bus.err_sum_o   = err_sum_q;
  assign bus.fail_runs_o = fail_runs_q;
  assign bus.run_cnt_o   = run_cnt_q;

endmodule

// File: tb/tb_timing_test_host.sv
// Directed bench for timing_test_host with a scripted test-block model that
// presents an error count once we_o has been high for two cycles.
module tb_timing_test_host;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timing_test_host_if bus ();

  timing_test_host #(
    .WE_HOLD (3),
    .RUN_WAIT(20),
    .GAP     (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nv = 0;
  int nf = 0;

  logic [9:0]  script [256];
  int          sidx = 0;
  logic        we_d1 = 1'b0;
  logic        armed = 1'b0;
  logic [9:0]  model_val = 10'd0;
  logic        tog_mode = 1'b0;
  logic [31:0] tog_val = 32'd0;

  assign bus.tt_data_i = tog_mode ? tog_val : {22'd0, model_val};

  // Test-block model: loads the next scripted count on the second high sample of we.
  always @(negedge clk) begin
    if (!bus.busy_o) begin
      sidx  <= 0;
      armed <= 1'b0;
      we_d1 <= 1'b0;
    end else begin
      we_d1 <= bus.we_o;
      if (bus.we_o && we_d1 && !armed) begin
        model_val <= script[sidx];
        sidx      <= sidx + 1;
        armed     <= 1'b1;
      end else if (!bus.we_o) begin
        armed <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nv++;
    assert (obs === exp)
    else begin
      nf++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag, input int last, input int mn, input int mx,
                           input int sum, input int fails, input int cnt);
    chk({tag, "_last"}, 32'(bus.err_last_o), 32'(last));
    chk({tag, "_min"}, 32'(bus.err_min_o), 32'(mn));
    chk({tag, "_max"}, 32'(bus.err_max_o), 32'(mx));
    chk({tag, "_sum"}, 32'(bus.err_sum_o), 32'(sum));
    chk({tag, "_fail"}, 32'(bus.fail_runs_o), 32'(fails));
    chk({tag, "_cnt"}, 32'(bus.run_cnt_o), 32'(cnt));
  endtask

  // Cycle k is the period after edge k-1, edge 0 being the one that samples start_i.
  int done_k, we_hi, we_max, gap_min, busy_low, first_min, first_last, first_sum;

  task automatic run_seq(input logic [7:0] runs, input int extra_k);
    int k, hi_run, lo_run;
    bit seen_hi;
    @(posedge clk);
    @(negedge clk);
    bus.runs_i  = runs;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.runs_i  = 8'hA5;
    k = 1; hi_run = 0; lo_run = 0; seen_hi = 0;
    done_k = -1; we_hi = 0; we_max = 0; gap_min = 1000000; busy_low = 0;
    first_min  = int'(bus.err_min_o);
    first_last = int'(bus.err_last_o);
    first_sum  = int'(bus.err_sum_o);
    while (k <= 8000 && done_k < 0) begin
      if (tog_mode) tog_val = {22'(32'h15555 ^ k), (k == 24) ? 10'd321 : 10'(k * 37)};
      if (bus.we_o) begin
        if (seen_hi && lo_run > 0 && lo_run < gap_min) gap_min = lo_run;
        lo_run = 0; hi_run++; we_hi++; seen_hi = 1;
        if (hi_run > we_max) we_max = hi_run;
      end else begin
        hi_run = 0; lo_run++;
      end
      if (!bus.busy_o) busy_low++;
      if (bus.done_o) done_k = k;
      bus.start_i = (k == extra_k);
      if (done_k < 0) begin
        @(posedge clk);
        #1;
        k++;
      end
    end
  endtask

  initial begin
    bool_init();
  end

  task automatic bool_init();
    int dn;
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.runs_i  = 8'd0;
    for (int i = 0; i < 256; i++) script[i] = 10'd0;
    #1;
    chk("rst_we", 32'(bus.we_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    chk_stats("rst", 0, 10'h3FF, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single run
    script[0] = 10'd7;
    run_seq(8'd1, -1);
    chk("single_done_cyc", 32'(done_k), 25);
    chk("single_we_cycles", 32'(we_hi), 3);
    chk("single_we_stretch", 32'(we_max), 3);
    chk("single_busy_gap", 32'(busy_low), 0);
    chk_stats("single", 7, 7, 7, 7, 1, 1);

    // Multi-run, started in the cycle right after DONE
    script[0] = 10'd0; script[1] = 10'd5; script[2] = 10'd2; script[3] = 10'd9;
    run_seq(8'd4, -1);
    chk("multi_clr_min", 32'(first_min), 10'h3FF);
    chk("multi_hold_last", 32'(first_last), 7);
    chk("multi_clr_sum", 32'(first_sum), 0);
    chk("multi_done_cyc", 32'(done_k), 103);
    chk("multi_we_cycles", 32'(we_hi), 12);
    chk("multi_we_stretch", 32'(we_max), 3);
    chk("multi_we_gap", 32'(gap_min), 23);
    chk_stats("multi", 9, 0, 9, 16, 3, 4);

    // runs_i = 0 with a stray start at cycle 10
    script[0] = 10'd6;
    run_seq(8'd0, 10);
    chk("zero_done_cyc", 32'(done_k), 25);
    chk("zero_we_cycles", 32'(we_hi), 3);
    chk_stats("zero", 6, 6, 6, 6, 1, 1);

    // start_i during DONE is dropped
    script[0] = 10'd3;
    run_seq(8'd1, 25);
    chk("dstart_done_cyc", 32'(done_k), 25);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    chk("dstart_idle1", 32'(bus.busy_o), 0);
    @(posedge clk);
    #1;
    chk("dstart_idle2", 32'(bus.busy_o), 0);
    chk("dstart_cnt", 32'(bus.run_cnt_o), 1);

    // Full range: 255 runs of 1023
    for (int i = 0; i < 256; i++) script[i] = 10'h3FF;
    run_seq(8'd255, -1);
    chk("sat_done_cyc", 32'(done_k), 6629);
    chk_stats("sat", 1023, 1023, 1023, 260865, 255, 255);

    // Reset in WAIT of run 2 of 4 (cycles 30..49)
    for (int i = 0; i < 4; i++) script[i] = 10'd8;
    @(posedge clk);
    @(negedge clk);
    bus.runs_i  = 8'd4;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    dn = 0;
    for (int k = 1; k < 35; k++) begin
      if (bus.done_o) dn++;
      @(posedge clk);
      #1;
    end
    chk("mrst_pre_cnt", 32'(bus.run_cnt_o), 1);
    chk("mrst_pre_we", 32'(bus.we_o), 0);
    rst = 1'b1;
    #1;
    chk("mrst_we", 32'(bus.we_o), 0);
    chk("mrst_busy", 32'(bus.busy_o), 0);
    chk_stats("mrst", 0, 10'h3FF, 0, 0, 0, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done_o) dn++;
    end
    chk("mrst_no_done", 32'(dn), 0);
    @(negedge clk);
    rst = 1'b0;
    script[0] = 10'd4;
    run_seq(8'd1, -1);
    chk("post_done_cyc", 32'(done_k), 25);
    chk_stats("post", 4, 4, 4, 4, 1, 1);

    // tt_data_i toggles every cycle; only the SAMPLE-cycle value may land
    tog_mode = 1'b1;
    tog_val  = 32'hFFFF_FFFF;
    run_seq(8'd1, -1);
    chk("tog_done_cyc", 32'(done_k), 25);
    chk_stats("tog", 321, 321, 321, 321, 1, 1);
    tog_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  endtask

endmodule

// File: doc/timing_test_host.md
# timing_test_host

Initiator side of the inverter-chain timing-test handshake. It drives the test block's write-enable input with correctly shaped launch pulses and waits a fixed settle window. It then samples the 10-bit error count from the block's result bus and accumulates statistics over a programmable number of runs. It sits between the SoC control logic and one timing-test instance and turns a single `start_i` pulse into a complete multi-run characterisation.

## Interface
Parameters:
- `WE_HOLD`, default 3: cycles `we_o` is held high per launch. Must be ≥3, because the test block starts only when `we` is high in two consecutive registered samples.
- `RUN_WAIT`, default 600: cycles waited after `we_o` falls before sampling. This covers 512 chains plus FSM overhead.
- `GAP`, default 2: cycles `we_o` is held low between runs so the test block re-arms. Must be ≥2.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start_i` input 1: one-cycle request to begin a sequence. Ignored while `busy_o` = 1.
- `runs_i` input 8: number of runs. Latched when `start_i` is accepted; value 0 is treated as 1.
- `tt_data_i` input 32: result bus from the test block. Only bits [9:0] are used.
- `we_o` output 1: launch enable to the test block.
- `busy_o` output 1: high from the cycle after `start_i` is accepted through the DONE cycle.
- `done_o` output 1: one-cycle pulse when the sequence completes.
- `err_last_o` output 10: error count of the most recent run.
- `err_min_o` output 10: minimum error count over the runs of this sequence.
- `err_max_o` output 10: maximum error count over the runs of this sequence.
- `err_sum_o` output 18: sum of error counts over the runs of this sequence.
- `fail_runs_o` output 8: number of runs with a nonzero error count.
- `run_cnt_o` output 8: number of runs completed in this sequence.

## Operation
FSM states: IDLE, ARM, WAIT, SAMPLE, GAP, DONE.
- **IDLE**: `start_i` = 1 latches `runs_i`, clears the statistics, and moves to ARM.
  - Cleared values: `err_min_o` = 10'h3FF; `err_max_o`, `err_sum_o`, `fail_runs_o`, `run_cnt_o` = 0.
  - `err_last_o` holds its previous value.
- **ARM**: `we_o` = 1 for exactly `WE_HOLD` cycles, then move to WAIT.
- **WAIT**: `we_o` = 0. Count `RUN_WAIT` cycles, then move to SAMPLE.
- **SAMPLE**: one cycle. On its closing edge, with d = `tt_data_i[9:0]`:
  - `err_last_o` ← d.
  - `err_min_o` ← min(`err_min_o`, d).
  - `err_max_o` ← max(`err_max_o`, d).
  - `err_sum_o` ← `err_sum_o` + d.
  - `fail_runs_o` increments if d ≠ 0.
  - `run_cnt_o` increments.
  - Next state: DONE if this was the last latched run, otherwise GAP.
- **GAP**: `we_o` = 0 for `GAP` cycles, then move to ARM.
- **DONE**: `done_o` = 1 for one cycle; all statistics are final. Next state is IDLE.
- Width rules:
  - `err_sum_o` is 18 bits; its maximum is 255×1023 = 260865, so it cannot overflow.
  - `fail_runs_o` and `run_cnt_o` cannot exceed 255.
- `we_o` is driven only from the registered state (`we_o` = state==ARM). It is glitch-free and never high outside ARM.

## Timing
- Reset values: all outputs are 0, except `err_min_o` = 10'h3FF. The state is IDLE. Reset forces `we_o` low asynchronously.
- Take edge 0 as the edge that samples `start_i` = 1.
  - `busy_o` and `we_o` rise after edge 0.
  - `we_o` is high for cycles 1..WE_HOLD.
  - WAIT occupies the next `RUN_WAIT` cycles.
  - SAMPLE occupies cycle WE_HOLD+RUN_WAIT+1.
- Single run: `done_o` is high in cycle WE_HOLD+RUN_WAIT+2, and statistics are valid in that same cycle.
- N runs: each run after the first adds GAP+WE_HOLD+RUN_WAIT+1 cycles before `done_o`.
- `busy_o` falls together with `done_o` at the end of the DONE cycle.
- Boundary behaviour:
  - `start_i` in DONE or any busy state is dropped, with no queueing.
  - `start_i` in the cycle after DONE (IDLE) is accepted.
  - `runs_i` = 0 behaves identically to `runs_i` = 1.
  - `runs_i` changes after acceptance have no effect.
  - `tt_data_i` is sampled only in SAMPLE; changes at any other time are ignored.
  - Reset asserted mid-sequence:
    - Immediate return to IDLE with reset values.
    - No `done_o` pulse.
    - After reset is released, a new `start_i` runs normally.

## Test plan
Bench parameters: WE_HOLD=3, RUN_WAIT=20, GAP=2. A test-block model returns a scripted error count after `we` has been high for two cycles.
- **Single run**: `runs_i`=1 with model count 7. Expect `we_o` high for exactly 3 cycles, `done_o` at cycle 25, last=min=max=7, sum=7, fail_runs=1, run_cnt=1.
- **Multi-run statistics**: `runs_i`=4 with counts 0, 5, 2, 9. Expect min=0, max=9, sum=16, fail_runs=3, run_cnt=4, last=9, `done_o` at cycle 25+3×26=103. `we_o` must be low for ≥2 cycles between launches.
- **Zero and ignored starts**:
  - `runs_i`=0 must behave exactly as 1 run.
  - A second `start_i` pulse at cycle 10 must produce no extra run and no timing change.
- **Saturation range**: `runs_i`=255 with every count 1023. Expect sum=260865, max=min=1023, fail_runs=255.
- **Mid-sequence reset**: assert `rst` during WAIT of run 2 of 4.
  - Expect `we_o`=0 at once, all outputs at reset values, min=3FF, no `done_o`.
  - A following `start_i` with `runs_i`=1 and count 4 completes normally with sum=4.
- **Data stability**: toggle `tt_data_i` every cycle except in SAMPLE. Only the value present during SAMPLE may be captured.
